// File: rtl/qsys_system_pio_chaos_key_capture_pkg.sv
// Shared constants for the chaos key capture PIO: register offsets, STATUS bit
// positions, data width and the interrupt reduction helper.
package qsys_system_pio_chaos_key_capture_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_COUNT   = 2'd3
    } reg_addr_e;

    localparam int STATUS_FULL_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    // Interrupt is raised when any enabled flag is set.
    function automatic logic irq_from_flags(input logic [1:0] flags, input logic [1:0] mask);
        return |(flags & mask);
    endfunction

endpackage

// File: rtl/qsys_system_pio_chaos_key_capture.sv
// Single-entry capture register for chaos key words, exposed to a Nios II as an
// Avalon-MM slave with full/overrun flags, an interrupt mask and an accept counter.
module qsys_system_pio_chaos_key_capture
    import qsys_system_pio_chaos_key_capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] key_data,
    input  logic              key_valid,
    output logic              irq
);

    logic [DATA_W-1:0] data_r;
    logic              full_r;
    logic              overrun_r;
    logic [1:0]        irq_mask_r;
    logic [DATA_W-1:0] count_r;
    logic              irq_r;

    logic consume_s;
    logic write_s;
    logic accept_s;
    logic overrun_evt_s;
    logic status_w1c_s;
    logic count_clr_s;
    logic mask_wr_s;
    logic unused_s;

    assign consume_s     = chipselect && !read_n && (address == REG_DATA);
    assign write_s       = chipselect && !write_n;
    // A consume frees the slot on the same edge, so a coincident key is accepted.
    assign accept_s      = key_valid && (!full_r || consume_s);
    assign overrun_evt_s = key_valid && full_r && !consume_s;
    assign status_w1c_s  = write_s && (address == REG_STATUS) && writedata[STATUS_OVERRUN_BIT];
    assign count_clr_s   = write_s && (address == REG_COUNT);
    assign mask_wr_s     = write_s && (address == REG_IRQMASK);
    assign unused_s      = ^writedata[DATA_W-1:2];

    // Holding register, flags, mask, counter and registered interrupt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_r     <= {DATA_W{1'b0}};
            full_r     <= 1'b0;
            overrun_r  <= 1'b0;
            irq_mask_r <= 2'b00;
            count_r    <= {DATA_W{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                data_r <= key_data;
                full_r <= 1'b1;
            end else if (consume_s) begin
                full_r <= 1'b0;
            end

            // A fresh overrun outranks a software clear in the same cycle.
            if (overrun_evt_s) begin
                overrun_r <= 1'b1;
            end else if (status_w1c_s) begin
                overrun_r <= 1'b0;
            end

            if (mask_wr_s) begin
                irq_mask_r <= writedata[1:0];
            end

            if (accept_s) begin
                count_r <= count_clr_s ? {{(DATA_W-1){1'b0}}, 1'b1} : count_r + 32'd1;
            end else if (count_clr_s) begin
                count_r <= {DATA_W{1'b0}};
            end

            irq_r <= irq_from_flags({overrun_r, full_r}, irq_mask_r);
        end
    end

    assign irq = irq_r;

    // Zero-latency register read mux.
    always_comb begin
        readdata = {DATA_W{1'b0}};
        if (chipselect) begin
            case (reg_addr_e'(address))
                REG_DATA: readdata = data_r;
                REG_STATUS: begin
                    readdata[STATUS_FULL_BIT]    = full_r;
                    readdata[STATUS_OVERRUN_BIT] = overrun_r;
                end
                REG_IRQMASK: readdata[1:0] = irq_mask_r;
                REG_COUNT:   readdata = count_r;
                default:     readdata = {DATA_W{1'b0}};
            endcase
        end else begin
            readdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_qsys_system_pio_chaos_key_capture.sv
// Self-checking bench for the chaos key capture PIO; DATA expectations flow
// through a scoreboard queue filled when keys are accepted.
module tb_qsys_system_pio_chaos_key_capture;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] key_data;
    logic        key_valid;
    logic        irq;

    int total;
    int bad;
    logic [31:0] sb[$];
    logic [31:0] exp_count;
    logic [31:0] rd;
    logic [31:0] exp;

    qsys_system_pio_chaos_key_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        #1 d = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic key_pulse(input logic [31:0] d);
        @(negedge clk);
        key_valid = 1'b1; key_data = d;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        key_pulse(32'hCAFE_0001);
        bus_write(2'd2, 32'h0000_0003);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        exp_count = 32'd0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b need=0", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(i[1:0], rd);
            total++;
            if (rd !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h need=0", i, rd); end
        end
    endtask

    task automatic test_accept();
        key_pulse(32'hA5A5_1234);
        sb.push_back(32'hA5A5_1234); exp_count++;
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL accept_status got=%h need=1", rd); end
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL accept_count got=%h need=%h", rd, exp_count); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL accept_data got=%h need=%h", rd, exp); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL consume_full got=%h need=0", rd); end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'h0000_0001);
        key_pulse(32'h0000_005A);
        sb.push_back(32'h0000_005A); exp_count++;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%0b need=0", irq); end
        @(posedge clk); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%0b need=1", irq); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL irq_data got=%h need=%h", rd, exp); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%0b need=1", irq); end
        @(posedge clk); #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%0b need=0", irq); end
        bus_write(2'd2, 32'hFFFF_FFFC);
        bus_read(2'd2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mask_upper got=%h need=0", rd); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL mask_load got=%h need=3", rd); end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_overrun();
        key_pulse(32'h0000_0001);
        sb.push_back(32'h0000_0001); exp_count++;
        key_pulse(32'h0000_0002);
        bus_write(2'd0, 32'h1234_5678);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL overrun_status got=%h need=3", rd); end
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL overrun_count got=%h need=%h", rd, exp_count); end
        bus_write(2'd1, 32'h0000_0002);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL w1c_status got=%h need=1", rd); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL overrun_data got=%h need=%h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        key_pulse(32'h0000_0011);
        sb.push_back(32'h0000_0011); exp_count++;
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        key_valid = 1'b1; key_data = 32'hDEAD_BEEF;
        #1 rd = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0; read_n = 1'b1; key_valid = 1'b0;
        exp = sb.pop_front();
        sb.push_back(32'hDEAD_BEEF); exp_count++;
        total++; if (rd !== exp) begin bad++; $display("FAIL b2b_old got=%h need=%h", rd, exp); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL b2b_status got=%h need=1", rd); end
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL b2b_count got=%h need=%h", rd, exp_count); end
        // Overrun in the same cycle as a W1C must keep OVERRUN set.
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h2;
        key_valid = 1'b1; key_data = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1; key_valid = 1'b0;
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL w1c_race got=%h need=3", rd); end
        bus_write(2'd1, 32'h2);
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL b2b_data got=%h need=%h", rd, exp); end
    endtask

    task automatic test_count();
        @(negedge clk);
        chipselect = 1'b0; address = 2'd3;
        #1 total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL no_cs got=%h need=0", readdata); end
        bus_write(2'd3, 32'h0);
        exp_count = 32'd0;
        @(negedge clk);
        force dut.count_r = 32'hFFFF_FFFF;
        #1 release dut.count_r;
        exp_count = 32'hFFFF_FFFF;
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL count_pre got=%h need=%h", rd, exp_count); end
        key_pulse(32'h0000_0033);
        sb.push_back(32'h0000_0033); exp_count++;
        bus_read(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL count_wrap got=%h need=0", rd); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL count_data got=%h need=%h", rd, exp); end
        key_pulse(32'h0000_0044);
        key_pulse(32'h0000_0045);
        bus_read(2'd0, rd);
        bus_write(2'd1, 32'h2);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h0;
        key_valid = 1'b1; key_data = 32'h0000_0055;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1; key_valid = 1'b0;
        sb.push_back(32'h0000_0055); exp_count = 32'd1;
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL count_clr_accept got=%h need=%h", rd, exp_count); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL clr_data got=%h need=%h", rd, exp); end
    endtask

    task automatic test_mid_reset();
        key_pulse(32'h0000_0066);
        key_pulse(32'h0000_0067);
        bus_write(2'd2, 32'h3);
        repeat (2) @(posedge clk);
        #1 total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%0b need=1", irq); end
        @(negedge clk);
        reset_n = 1'b0; key_valid = 1'b1; key_data = 32'h0000_0099;
        @(posedge clk);
        #1 reset_n = 1'b1; key_valid = 1'b0;
        sb.delete(); exp_count = 32'd0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq got=%0b need=0", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(i[1:0], rd);
            total++;
            if (rd !== 32'd0) begin bad++; $display("FAIL mid_reset_reg%0d got=%h need=0", i, rd); end
        end
        key_pulse(32'h0000_0077);
        sb.push_back(32'h0000_0077); exp_count++;
        bus_read(2'd3, rd);
        total++; if (rd !== exp_count) begin bad++; $display("FAIL first_accept_count got=%h need=%h", rd, exp_count); end
        bus_read(2'd0, rd);
        exp = sb.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL first_accept_data got=%h need=%h", rd, exp); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = 32'd0; key_data = 32'd0; key_valid = 1'b0; exp_count = 32'd0;
        test_reset();
        test_accept();
        test_irq();
        test_overrun();
        test_back_to_back();
        test_count();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsys_system_pio_chaos_key_capture.md
QSYS_SYSTEM_PIO_CHAOS_KEY_CAPTURE -- requirements
Module: qsys_system_pio_chaos_key_capture

Interface
REQ-001 Module SHALL use one clock; reset is synchronous and active-low; ports are named clk and reset_n.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 address  input  2  Avalon-MM word address.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 read_n  input  1  Avalon-MM read strobe, active-low.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data; combinational, read latency 0, no waitrequest.
REQ-010 key_data  input  32  chaos key word from the key-shift datapath; synchronous to clk.
REQ-011 key_valid  input  1  single-cycle qualifier for key_data; synchronous to clk.
REQ-012 irq  output  1  level interrupt to the Nios II processor.

Function
REQ-013 Register map: 0 DATA (RO), 1 STATUS (bit0 FULL RO, bit1 OVERRUN W1C), 2 IRQMASK (RW, bits1:0), 3 COUNT (RO, write clears).
REQ-014 Unused readdata bits SHALL read 0; readdata SHALL be 0 when chipselect=0.
REQ-015 Accept: key_valid=1 and FULL=0 SHALL load DATA with key_data, set FULL, and increment COUNT on the same edge.
REQ-016 Consume: chipselect=1, read_n=0, address=0 SHALL return DATA combinationally and clear FULL on that edge.
REQ-017 Overrun: key_valid=1 with FULL=1 and no consume SHALL leave DATA unchanged, set OVERRUN, and leave COUNT unchanged.
REQ-018 Simultaneous consume and key_valid: DATA SHALL load the new key, FULL SHALL stay 1, COUNT SHALL increment, OVERRUN SHALL be unchanged.
REQ-019 Write to STATUS with writedata[1]=1 SHALL clear OVERRUN; a same-cycle overrun event SHALL win and keep OVERRUN=1.
REQ-020 Write to IRQMASK SHALL load writedata[1:0]; other bits SHALL be ignored.
REQ-021 COUNT SHALL be 32-bit unsigned, wrap from 0xFFFFFFFF to 0; a write to address 3 SHALL clear it; a same-cycle accept SHALL produce COUNT=1.
REQ-022 irq SHALL be registered: irq = OR of ({OVERRUN,FULL} AND IRQMASK), updated one cycle after flag or mask changes.
REQ-023 Reads of addresses 1 to 3 SHALL have no side effects; writes to address 0 SHALL be ignored.

Reset
REQ-024 reset_n=0 on a rising edge SHALL clear DATA, FULL, OVERRUN, IRQMASK, COUNT and irq to 0.
REQ-025 key_valid, reads and writes SHALL be ignored during reset; a key arriving mid-reset SHALL be lost without setting OVERRUN.
REQ-026 The first accept after reset_n deasserts SHALL behave as REQ-015.

Structure
REQ-027 A shared package SHALL hold the register offsets (DATA=0, STATUS=1, IRQMASK=2, COUNT=3), the STATUS bit indices (FULL=0, OVERRUN=1) and the data width constant (32).
REQ-028 The block SHALL be a single module with no sub-modules; the holding register and flags SHALL form one always block, and the register read mux SHALL be one combinational block.

Verification
REQ-029 Reset, then key_valid pulse with key_data=0xA5A5_1234 -> FULL=1, COUNT=1; read address 0 returns 0xA5A5_1234 and FULL=0 on the next cycle.
REQ-030 IRQMASK=0x1, accept one key -> irq=1 one cycle later; consume -> irq=0 one cycle after the read.
REQ-031 Two keys 0x1 then 0x2 with no read -> DATA=0x1, OVERRUN=1, COUNT=1; write STATUS 0x2 -> OVERRUN=0.
REQ-032 Consume and key_valid (0xDEAD_BEEF) in the same cycle -> DATA=0xDEAD_BEEF, FULL=1, OVERRUN=0, COUNT incremented.
REQ-033 Preload COUNT to 0xFFFFFFFF via accepts, accept one more -> COUNT=0; write address 3 during an accept -> COUNT=1.
REQ-034 Assert reset_n=0 for one cycle while FULL=1, OVERRUN=1, IRQMASK=0x3 -> all registers read 0 and irq=0.
